// File: rtl/lock_pkg.sv
// Shared definitions for the lock supervisor: key bus layout, FSM states and
// a one-hot helper used by the key event detector.
package lock_pkg;

  localparam int KEY_W        = 12;
  localparam int KEY_STAR     = 10;
  localparam int KEY_HASH     = 11;
  localparam int DIGIT_MSB    = 9;
  localparam int MAX_FAIL_DEF = 3;
  localparam int FAIL_W       = $clog2(MAX_FAIL_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RESP,
    OPEN,
    CLEAR,
    LOCKOUT
  } state_t;

  function automatic logic is_one_hot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - 12'd1)) == '0);
  endfunction

endpackage

// File: rtl/lock_supervisor_if.sv
// Keypad/lock side bundle of the lock supervisor; master is the keypad and
// lock environment, slave is the supervisor itself.
interface lock_supervisor_if;
  import lock_pkg::*;

  logic [KEY_W-1:0]  key_in;
  logic              door_open;
  logic [KEY_W-1:0]  key_out;
  logic              lock_clr;
  logic              unlock;
  logic              lockout;
  logic [FAIL_W-1:0] fail_cnt;
  logic              busy;

  modport master (
    output key_in, door_open,
    input  key_out, lock_clr, unlock, lockout, fail_cnt, busy
  );

  modport slave (
    input  key_in, door_open,
    output key_out, lock_clr, unlock, lockout, fail_cnt, busy
  );

endinterface

// File: rtl/key_event_det.sv
// Turns the raw keypad level into a single-cycle event strobe on the first
// cycle of a clean one-hot press, plus the decoded key class.
module key_event_det
  import lock_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_in,
  output logic             key_evt,
  output logic             is_digit,
  output logic             is_star,
  output logic             is_hash
);

  logic [KEY_W-1:0] key_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) key_q <= '0;
    else       key_q <= key_in;
  end

  // A press only counts when the bus was idle the cycle before, so held keys
  // and keys rolling over from a multi-hot chord never fire twice.
  always_comb begin
    key_evt  = (key_q == '0) && is_one_hot(key_in);
    is_digit = |key_in[DIGIT_MSB:0];
    is_star  = key_in[KEY_STAR];
    is_hash  = key_in[KEY_HASH];
  end

endmodule

// File: rtl/lock_supervisor.sv
// Sequences code attempts into the combination lock: counts digits, waits for
// the lock's verdict, times the open window, and enforces lockout on failures.
module lock_supervisor
  import lock_pkg::*;
#(
  parameter int PW_LEN      = 6,
  parameter int RESP_CYCLES = 8,
  parameter int OPEN_CYCLES = 20,
  parameter int MAX_FAIL    = MAX_FAIL_DEF,
  parameter int LOCK_CYCLES = 50,
  parameter int CLR_CYCLES  = 2
) (
  input logic               clk,
  input logic               reset,
  lock_supervisor_if.slave  bus
);

  localparam int MAX_A   = (RESP_CYCLES > OPEN_CYCLES) ? RESP_CYCLES : OPEN_CYCLES;
  localparam int MAX_B   = (LOCK_CYCLES > CLR_CYCLES) ? LOCK_CYCLES : CLR_CYCLES;
  localparam int TMR_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int CNT_W   = $clog2(PW_LEN + 1);

  localparam logic [TMR_W-1:0]  RESP_T  = TMR_W'(RESP_CYCLES);
  localparam logic [TMR_W-1:0]  OPEN_T  = TMR_W'(OPEN_CYCLES);
  localparam logic [TMR_W-1:0]  LOCK_T  = TMR_W'(LOCK_CYCLES);
  localparam logic [TMR_W-1:0]  CLR_T   = TMR_W'(CLR_CYCLES);
  localparam logic [TMR_W-1:0]  TMR_ONE = TMR_W'(1);
  localparam logic [CNT_W-1:0]  PW_FULL = CNT_W'(PW_LEN);
  localparam logic [CNT_W-1:0]  PW_LAST = CNT_W'(PW_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIM = FAIL_W'(MAX_FAIL);

  state_t            state, state_n;
  logic [TMR_W-1:0]  timer, timer_n;
  logic [CNT_W-1:0]  dig_cnt, dig_cnt_n;
  logic [FAIL_W-1:0] fail_q, fail_n, fail_inc;
  logic              door_q;
  logic              tmr_last;
  logic              key_evt, is_digit, is_star, is_hash;

  key_event_det u_key_det (
    .clk      (clk),
    .reset    (reset),
    .key_in   (bus.key_in),
    .key_evt  (key_evt),
    .is_digit (is_digit),
    .is_star  (is_star),
    .is_hash  (is_hash)
  );

  // Next-state logic; every timed state loads the shared timer on entry and
  // leaves on the cycle the timer reads 1.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    dig_cnt_n = dig_cnt;
    fail_n    = fail_q;
    tmr_last  = (timer == TMR_ONE);
    fail_inc  = fail_q + 1'b1;
    case (state)
      IDLE: begin
        if (bus.door_open && !door_q) begin
          state_n = OPEN;
          timer_n = OPEN_T;
          fail_n  = '0;
        end else if (key_evt) begin
          if (is_star) begin
            dig_cnt_n = '0;
          end else if (is_hash) begin
            state_n = WAIT_RESP;
            timer_n = RESP_T;
          end else if (is_digit) begin
            dig_cnt_n = (dig_cnt == PW_FULL) ? dig_cnt : dig_cnt + 1'b1;
            if (dig_cnt >= PW_LAST) begin
              state_n = WAIT_RESP;
              timer_n = RESP_T;
            end
          end
        end
      end
      WAIT_RESP: begin
        // A late open in the final cycle still counts as success.
        if (bus.door_open) begin
          state_n = OPEN;
          timer_n = OPEN_T;
          fail_n  = '0;
        end else if (tmr_last) begin
          fail_n = fail_inc;
          if (fail_inc == FAIL_LIM) begin
            state_n = LOCKOUT;
            timer_n = LOCK_T;
          end else begin
            state_n = CLEAR;
            timer_n = CLR_T;
          end
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      OPEN: begin
        if (tmr_last) begin
          state_n = CLEAR;
          timer_n = CLR_T;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      CLEAR: begin
        dig_cnt_n = '0;
        if (tmr_last) state_n = IDLE;
        else          timer_n = timer - 1'b1;
      end
      LOCKOUT: begin
        if (tmr_last) begin
          fail_n  = '0;
          state_n = CLEAR;
          timer_n = CLR_T;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state register and never see the inputs combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      dig_cnt      <= '0;
      fail_q       <= '0;
      door_q       <= 1'b0;
      bus.key_out  <= '0;
      bus.lock_clr <= 1'b0;
      bus.unlock   <= 1'b0;
      bus.lockout  <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      dig_cnt      <= dig_cnt_n;
      fail_q       <= fail_n;
      door_q       <= bus.door_open;
      bus.key_out  <= (state == IDLE) ? bus.key_in : '0;
      bus.lock_clr <= (state_n == CLEAR);
      bus.unlock   <= (state_n == OPEN);
      bus.lockout  <= (state_n == LOCKOUT);
      bus.busy     <= (state_n != IDLE);
    end
  end

  assign bus.fail_cnt = fail_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// Self-checking bench for lock_supervisor: pulse widths and fail counts are
// queued as stimulus is driven and checked by a monitor as pulses complete.
module tb_lock_supervisor;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  typedef struct {
    int width;
    int fail;
  } pulse_t;

  pulse_t exp_unlock[$];
  pulse_t exp_clr[$];
  pulse_t exp_lock[$];

  localparam logic [11:0] STAR = 12'h400;
  localparam logic [11:0] HASH = 12'h800;

  lock_supervisor_if bus ();

  lock_supervisor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [11:0] digitKey(input int d);
    logic [11:0] one;
    one = 12'h001;
    return one << (d % 10);
  endfunction

  // Called on a falling edge; holds the key for 'hold' cycles then releases.
  task automatic applyStimulus(input logic [11:0] key, input int hold);
    bus.key_in = key;
    repeat (hold) @(negedge clk);
    bus.key_in = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pressDigits(input int n, input int first);
    for (int i = 0; i < n; i++) applyStimulus(digitKey(first + i), 2);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle"}, int'(bus.busy), 0);
  endtask

  task automatic waitLockout(input int budget);
    int n;
    n = 0;
    while (!bus.lockout && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("lockout_reached", int'(bus.lockout), 1);
  endtask

  task automatic pulseReset(input string tag);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput({tag, "_key_out"},  int'(bus.key_out), 0);
    checkOutput({tag, "_lock_clr"}, int'(bus.lock_clr), 0);
    checkOutput({tag, "_unlock"},   int'(bus.unlock), 0);
    checkOutput({tag, "_lockout"},  int'(bus.lockout), 0);
    checkOutput({tag, "_fail_cnt"}, int'(bus.fail_cnt), 0);
    checkOutput({tag, "_busy"},     int'(bus.busy), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Measures every unlock/lock_clr/lockout pulse; pulses cut short by reset are discarded.
  initial begin : monitor
    int unlock_len, clr_len, lock_len, clr_fail, lock_fail;
    pulse_t p;
    unlock_len = 0;
    clr_len    = 0;
    lock_len   = 0;
    clr_fail   = 0;
    lock_fail  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        unlock_len = 0;
        clr_len    = 0;
        lock_len   = 0;
      end else begin
        if (bus.unlock) unlock_len++;
        else if (unlock_len > 0) begin
          if (exp_unlock.size() == 0) checkOutput("unlock_unexpected", unlock_len, 0);
          else begin
            p = exp_unlock.pop_front();
            checkOutput("unlock_width", unlock_len, p.width);
          end
          unlock_len = 0;
        end
        if (bus.lock_clr) begin
          if (clr_len == 0) clr_fail = int'(bus.fail_cnt);
          clr_len++;
        end else if (clr_len > 0) begin
          if (exp_clr.size() == 0) checkOutput("clr_unexpected", clr_len, 0);
          else begin
            p = exp_clr.pop_front();
            checkOutput("clr_width", clr_len, p.width);
            checkOutput("clr_fail_cnt", clr_fail, p.fail);
          end
          clr_len = 0;
        end
        if (bus.lockout) begin
          if (lock_len == 0) lock_fail = int'(bus.fail_cnt);
          lock_len++;
        end else if (lock_len > 0) begin
          if (exp_lock.size() == 0) checkOutput("lockout_unexpected", lock_len, 0);
          else begin
            p = exp_lock.pop_front();
            checkOutput("lockout_width", lock_len, p.width);
            checkOutput("lockout_fail_cnt", lock_fail, p.fail);
          end
          lock_len = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n;
    compared      = 0;
    mismatched    = 0;
    reset         = 1'b1;
    bus.key_in    = '0;
    bus.door_open = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_key_out",  int'(bus.key_out), 0);
    checkOutput("rst_lock_clr", int'(bus.lock_clr), 0);
    checkOutput("rst_unlock",   int'(bus.unlock), 0);
    checkOutput("rst_lockout",  int'(bus.lockout), 0);
    checkOutput("rst_fail_cnt", int'(bus.fail_cnt), 0);
    checkOutput("rst_busy",     int'(bus.busy), 0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] held key, two-hot value and key_out delay");
    bus.key_in = 12'h002;
    checkOutput("keyout_before_edge", int'(bus.key_out), 0);
    @(negedge clk);
    checkOutput("keyout_delay", int'(bus.key_out), 'h002);
    repeat (9) @(negedge clk);
    bus.key_in = '0;
    @(negedge clk);
    checkOutput("keyout_release", int'(bus.key_out), 0);
    bus.key_in = 12'h006;
    @(negedge clk);
    checkOutput("keyout_twohot", int'(bus.key_out), 'h006);
    bus.key_in = '0;
    repeat (2) @(negedge clk);
    pressDigits(4, 3);
    checkOutput("held_five_events", int'(bus.busy), 0);
    exp_clr.push_back('{2, 1});
    applyStimulus(digitKey(8), 2);
    checkOutput("held_sixth_ends", int'(bus.busy), 1);
    waitIdle("held", 40);

    $display("[TB] correct code, lock opens 3 cycles after the 6th event");
    exp_unlock.push_back('{20, 0});
    exp_clr.push_back('{2, 0});
    pressDigits(5, 0);
    bus.key_in = digitKey(5);
    repeat (3) @(negedge clk);
    bus.door_open = 1'b1;
    @(negedge clk);
    bus.key_in = '0;
    checkOutput("open_unlock", int'(bus.unlock), 1);
    n = 0;
    while (!bus.lock_clr && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("open_clr_seen", int'(bus.lock_clr), 1);
    bus.door_open = 1'b0;
    waitIdle("open", 20);
    checkOutput("open_fail_cnt", int'(bus.fail_cnt), 0);

    $display("[TB] two digits then hash");
    pressDigits(2, 4);
    checkOutput("hash_pre_busy", int'(bus.busy), 0);
    exp_clr.push_back('{2, 1});
    applyStimulus(HASH, 2);
    checkOutput("hash_busy", int'(bus.busy), 1);
    waitIdle("hash", 40);
    checkOutput("hash_fail_cnt", int'(bus.fail_cnt), 1);

    $display("[TB] star restarts the digit count");
    pressDigits(3, 0);
    applyStimulus(STAR, 2);
    pressDigits(5, 1);
    checkOutput("star_five_after", int'(bus.busy), 0);
    exp_clr.push_back('{2, 2});
    applyStimulus(digitKey(7), 2);
    checkOutput("star_sixth_ends", int'(bus.busy), 1);
    waitIdle("star", 40);
    checkOutput("star_fail_cnt", int'(bus.fail_cnt), 2);

    $display("[TB] three wrong codes lead to lockout");
    pulseReset("rst_idle");
    exp_clr.push_back('{2, 1});
    pressDigits(6, 2);
    waitIdle("wrong1", 40);
    exp_clr.push_back('{2, 2});
    pressDigits(6, 2);
    waitIdle("wrong2", 40);
    exp_lock.push_back('{50, 3});
    exp_clr.push_back('{2, 0});
    pressDigits(6, 2);
    waitLockout(30);
    bus.key_in = 12'h001;
    @(negedge clk);
    checkOutput("lockout_key_out", int'(bus.key_out), 0);
    checkOutput("lockout_level", int'(bus.lockout), 1);
    bus.key_in = '0;
    waitIdle("lockout", 100);
    checkOutput("lockout_fail_after", int'(bus.fail_cnt), 0);

    $display("[TB] reset during lockout");
    exp_clr.push_back('{2, 1});
    pressDigits(6, 1);
    waitIdle("again1", 40);
    exp_clr.push_back('{2, 2});
    pressDigits(6, 1);
    waitIdle("again2", 40);
    pressDigits(6, 1);
    waitLockout(30);
    repeat (10) @(negedge clk);
    pulseReset("rst_lockout");

    $display("[TB] reset during open");
    pressDigits(5, 0);
    bus.key_in = digitKey(5);
    @(negedge clk);
    bus.door_open = 1'b1;
    @(negedge clk);
    bus.key_in = '0;
    n = 0;
    while (!bus.unlock && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_open_unlock_seen", int'(bus.unlock), 1);
    repeat (5) @(negedge clk);
    bus.door_open = 1'b0;
    pulseReset("rst_open");
    repeat (3) @(negedge clk);
    checkOutput("rst_open_stays_idle", int'(bus.busy), 0);

    checkOutput("unlock_queue_left",  exp_unlock.size(), 0);
    checkOutput("clr_queue_left",     exp_clr.size(), 0);
    checkOutput("lockout_queue_left", exp_lock.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
